// File: rtl/h_tanh_oq.sv
// ---------------------------------------------------------------------------
// h_tanh_oq
// Quantized LSTM hidden-state stage: H_t = sigmoid(o) * tanh(C_t), one hidden
// element per transfer, through a 3-stage valid/ready pipeline. Elements are
// counted per hidden vector so the last one of each vector is flagged.
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   i_flush   synchronous abort: empties the pipeline, clears the counter
//   i_valid   input element valid
//   o_ready   block can accept an input element this cycle
//   i_cstate  quantized C_t, zero point ZERO_STATE, scale 128
//   i_ogate   quantized output gate, zero OUT_ZERO_SIGMOID, scale OUT_SCALE_SIGMOID
//   o_valid   H_t valid
//   i_ready   downstream accepts H_t
//   o_h       quantized H_t, zero ZERO_DATA, scale SCALE_DATA
//   o_last    high with the N_HIDDEN-th output of a vector
//   o_done    one-cycle pulse in the cycle after the o_last handshake
// ---------------------------------------------------------------------------
module h_tanh_oq #(
    parameter logic [7:0]  ZERO_STATE        = 8'd128,
    parameter logic [9:0]  OUT_SCALE_SIGMOID = 10'd256,
    parameter logic [7:0]  OUT_ZERO_SIGMOID  = 8'd0,
    parameter logic [9:0]  SCALE_DATA        = 10'd128,
    parameter logic [7:0]  ZERO_DATA         = 8'd128,
    parameter int unsigned N_HIDDEN          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_flush,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_cstate,
    input  logic [7:0] i_ogate,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_h,
    output logic       o_last,
    output logic       o_done
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_HIDDEN - 1);

    // Requantization constants kept as signed ints so the whole product and
    // quotient evaluate in signed arithmetic (division truncates toward zero).
    localparam int SCALE_I = int'(SCALE_DATA);
    localparam int DIV_I   = int'(OUT_SCALE_SIGMOID) * 128;
    localparam int ZD_I    = int'(ZERO_DATA);

    // Pipeline registers
    logic                   s1_valid_q, s1_valid_d;
    logic [7:0]             s1_mag_q,   s1_mag_d;
    logic                   s1_neg_q,   s1_neg_d;
    logic signed [8:0]      s1_g_q,     s1_g_d;

    logic                   s2_valid_q, s2_valid_d;
    logic signed [7:0]      s2_t_q,     s2_t_d;
    logic signed [8:0]      s2_g_q,     s2_g_d;

    logic                   s3_valid_q, s3_valid_d;
    logic [7:0]             h_q,        h_d;
    logic                   last_q,     last_d;
    logic                   done_q,     done_d;
    logic [CNT_W-1:0]       count_q,    count_d;

    // Handshake / advance controls
    logic en1_c, en2_c, en3_c;
    logic out_hs_c;

    // Datapath intermediates
    logic signed [8:0]  d_c;
    logic [7:0]         mag_c;
    logic signed [8:0]  g_c;
    logic [9:0]         seg_c;
    logic [7:0]         y_c;
    logic signed [7:0]  t_c;
    logic signed [31:0] prod_c;
    logic signed [31:0] quo_c;
    logic signed [31:0] u_c;
    logic [7:0]         h_c;

    // A stage may load when it is empty or its contents move on this cycle.
    assign en3_c    = !s3_valid_q || i_ready;
    assign en2_c    = !s2_valid_q || en3_c;
    assign en1_c    = !s1_valid_q || en2_c;
    assign out_hs_c = s3_valid_q && i_ready;

    assign o_ready = en1_c;
    assign o_valid = s3_valid_q;
    assign o_h     = h_q;
    assign o_last  = last_q;
    assign o_done  = done_q;

    // S1: remove zero points, split C_t into sign and magnitude
    always_comb begin
        d_c   = $signed({1'b0, i_cstate}) - $signed({1'b0, ZERO_STATE});
        mag_c = d_c[8] ? 8'(-d_c) : 8'(d_c);
        g_c   = $signed({1'b0, i_ogate}) - $signed({1'b0, OUT_ZERO_SIGMOID});
    end

    // S2: three-segment piecewise-linear tanh on the magnitude, sign restored
    always_comb begin
        seg_c = 10'd0;
        y_c   = s1_mag_q;
        if (s1_mag_q <= 8'd32) begin
            y_c = s1_mag_q;
        end else if (s1_mag_q <= 8'd80) begin
            seg_c = (10'(s1_mag_q) - 10'd32) * 10'd3;
            y_c   = 8'(10'd32 + (seg_c >> 2));
        end else begin
            seg_c = 10'(s1_mag_q) - 10'd80;
            y_c   = 8'(10'd68 + (seg_c >> 1));
        end
        t_c = s1_neg_q ? -$signed(y_c) : $signed(y_c);
    end

    // S3: rescale the gate*tanh product into the data domain and saturate
    always_comb begin
        prod_c = 32'(int'(s2_g_q) * int'(s2_t_q) * SCALE_I);
        quo_c  = prod_c / DIV_I;
        u_c    = quo_c + ZD_I;
        if (u_c < 0) begin
            h_c = 8'd0;
        end else if (u_c > 255) begin
            h_c = 8'd255;
        end else begin
            h_c = u_c[7:0];
        end
    end

    // Next-state: stage loads, element counter, last/done flags, flush
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mag_d   = s1_mag_q;
        s1_neg_d   = s1_neg_q;
        s1_g_d     = s1_g_q;
        s2_valid_d = s2_valid_q;
        s2_t_d     = s2_t_q;
        s2_g_d     = s2_g_q;
        s3_valid_d = s3_valid_q;
        h_d        = h_q;
        count_d    = count_q;
        done_d     = 1'b0;
        last_d     = 1'b0;

        if (en1_c) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_mag_d = mag_c;
                s1_neg_d = d_c[8];
                s1_g_d   = g_c;
            end
        end

        if (en2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_t_d = t_c;
                s2_g_d = s1_g_q;
            end
        end

        if (en3_c) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                h_d = h_c;
            end
        end

        if (out_hs_c) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + CNT_W'(1);
            done_d  = last_q;
        end

        // Flush wins over every handshake in its cycle; data regs are left
        // alone since nothing downstream looks at them while invalid.
        if (i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
            count_d    = '0;
            done_d     = 1'b0;
        end

        // o_last is registered: evaluated against the values S3 and the
        // counter will hold next cycle.
        last_d = s3_valid_d && (count_d == LAST_IDX);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= 8'd0;
            s1_neg_q   <= 1'b0;
            s1_g_q     <= 9'sd0;
            s2_valid_q <= 1'b0;
            s2_t_q     <= 8'sd0;
            s2_g_q     <= 9'sd0;
            s3_valid_q <= 1'b0;
            h_q        <= 8'd0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mag_q   <= s1_mag_d;
            s1_neg_q   <= s1_neg_d;
            s1_g_q     <= s1_g_d;
            s2_valid_q <= s2_valid_d;
            s2_t_q     <= s2_t_d;
            s2_g_q     <= s2_g_d;
            s3_valid_q <= s3_valid_d;
            h_q        <= h_d;
            last_q     <= last_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_h_tanh_oq.sv
// Bench for h_tanh_oq: three instances (ZERO_DATA 128/250/0) share stimulus;
// a queue-based reference model predicts every output cycle.
module tb_h_tanh_oq;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_flush;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] i_cstate;
    logic [7:0] i_ogate;

    logic       o_ready, o_valid, o_last, o_done;
    logic [7:0] o_h;
    logic       hi_ready, hi_valid, hi_last, hi_done;
    logic [7:0] hi_h;
    logic       lo_ready, lo_valid, lo_last, lo_done;
    logic [7:0] lo_h;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_out       = 0;
    int n_last      = 0;
    int n_done      = 0;

    // Reference model state: accepted elements in order, with accept cycle
    int qc[$];
    int qo[$];
    int qt[$];
    int cnt_m    = 0;
    bit done_exp = 1'b0;

    bit exp_v, exp_r, out_hs, in_hs;

    h_tanh_oq #(.N_HIDDEN(N)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_cstate(i_cstate), .i_ogate(i_ogate),
        .o_valid(o_valid), .i_ready(i_ready), .o_h(o_h), .o_last(o_last),
        .o_done(o_done)
    );

    h_tanh_oq #(.ZERO_DATA(8'd250), .N_HIDDEN(N)) dut_hi (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(hi_ready), .i_cstate(i_cstate), .i_ogate(i_ogate),
        .o_valid(hi_valid), .i_ready(i_ready), .o_h(hi_h), .o_last(hi_last),
        .o_done(hi_done)
    );

    h_tanh_oq #(.ZERO_DATA(8'd0), .N_HIDDEN(N)) dut_lo (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(lo_ready), .i_cstate(i_cstate), .i_ogate(i_ogate),
        .o_valid(lo_valid), .i_ready(i_ready), .o_h(lo_h), .o_last(lo_last),
        .o_done(lo_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // H_t straight from the arithmetic definition, plain integers
    function automatic int ref_h(input int c, input int o, input int zd);
        int d, a, y, t, q, u;
        d = c - 128;
        a = (d < 0) ? -d : d;
        if (a <= 32)      y = a;
        else if (a <= 80) y = 32 + ((a - 32) * 3) / 4;
        else              y = 68 + (a - 80) / 2;
        t = (d < 0) ? -y : y;
        q = (o * t * 128) / (256 * 128);
        u = q + zd;
        if (u < 0)   return 0;
        if (u > 255) return 255;
        return u;
    endfunction

    // Compare process: expectations for this cycle, then apply its events
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_o_valid", int'(o_valid), 0);
            chk("rst_o_h",     int'(o_h), 0);
            chk("rst_o_last",  int'(o_last), 0);
            chk("rst_o_done",  int'(o_done), 0);
            chk("rst_hi_h",    int'(hi_h), 0);
            qc.delete(); qo.delete(); qt.delete();
            cnt_m    = 0;
            done_exp = 1'b0;
        end else begin
            exp_v = 1'b0;
            if (qc.size() > 0) exp_v = (cyc >= qt[0] + 3);
            chk("o_valid", int'(o_valid), int'(exp_v));
            if (exp_v) begin
                chk("o_h",    int'(o_h),    ref_h(qc[0], qo[0], 128));
                chk("hi_h",   int'(hi_h),   ref_h(qc[0], qo[0], 250));
                chk("lo_h",   int'(lo_h),   ref_h(qc[0], qo[0], 0));
                chk("o_last", int'(o_last), int'(cnt_m == N - 1));
            end else begin
                chk("o_last_idle", int'(o_last), 0);
            end
            chk("o_done", int'(o_done), int'(done_exp));
            exp_r = (qc.size() < 3) || (exp_v && i_ready);
            chk("o_ready", int'(o_ready), int'(exp_r));

            if (o_done) n_done++;
            if (o_valid && i_ready && o_last) n_last++;

            out_hs = exp_v && i_ready;
            in_hs  = i_valid && exp_r;
            if (i_flush) begin
                qc.delete(); qo.delete(); qt.delete();
                cnt_m    = 0;
                done_exp = 1'b0;
            end else begin
                done_exp = out_hs && (cnt_m == N - 1);
                if (out_hs) begin
                    void'(qc.pop_front()); void'(qo.pop_front()); void'(qt.pop_front());
                    cnt_m = (cnt_m == N - 1) ? 0 : cnt_m + 1;
                    n_out++;
                end
                if (in_hs) begin
                    qc.push_back(int'(i_cstate));
                    qo.push_back(int'(i_ogate));
                    qt.push_back(cyc);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] c, input logic [7:0] o,
                         input bit r, input bit f);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        i_valid  = v;
        i_cstate = c;
        i_ogate  = o;
        i_ready  = r;
        i_flush  = f;
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        #1;
        acc = i_valid && o_ready && !i_flush && !reset;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) begin
            drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            tick(acc);
        end
    endtask

    task automatic send_one(input logic [7:0] c, input logic [7:0] o);
        bit acc;
        int g;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 50) begin
            drive(1'b1, c, o, 1'b1, 1'b0);
            tick(acc);
            g++;
        end
        chk("send_one_timeout", int'(acc), 1);
    endtask

    task automatic send_n(input int n, input bit rnd_ready);
        bit acc;
        int sent, g;
        sent = 0;
        g    = 0;
        while (sent < n && g < 2000) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            tick(acc);
            if (acc) sent++;
            g++;
        end
        chk("send_n_timeout", sent, n);
    endtask

    task automatic drain(input bit rnd_ready);
        bit acc;
        int g;
        g = 0;
        while (qc.size() > 0 && g < 300) begin
            drive(1'b0, 8'd0, 8'd0, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            tick(acc);
            g++;
        end
        chk("drain_timeout", qc.size(), 0);
    endtask

    // Stream with i_ready high until k more outputs have been delivered
    task automatic run_until_outputs(input int k);
        bit acc;
        int base, g;
        base = n_out;
        g    = 0;
        while (n_out - base < k && g < 100) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            tick(acc);
            g++;
        end
        chk("outputs_seen", n_out - base, k);
    endtask

    int b_out, b_last, b_done;
    bit acc_g;

    initial begin
        reset    = 1'b1;
        i_flush  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_cstate = 8'd0;
        i_ogate  = 8'd0;

        // Hand-computed anchors for the model
        chk("pin_zero_state", ref_h(128, 200, 128), 128);
        chk("pin_pos_mid",    ref_h(192, 255, 128), 183);
        chk("pin_neg_full",   ref_h(0,   128, 128), 82);
        chk("pin_sat_high",   ref_h(255, 255, 250), 255);
        chk("pin_sat_low",    ref_h(0,   255, 0),   0);

        repeat (3) @(posedge clk);

        // Directed vectors through the DUT
        send_one(8'd128, 8'd200);
        send_one(8'd192, 8'd255);
        send_one(8'd0,   8'd128);
        send_one(8'd255, 8'd255);
        send_one(8'd0,   8'd255);
        idle(6);
        chk("directed_outputs", n_out, 5);
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        tick(acc_g);

        // One full vector under random backpressure
        b_out = n_out; b_last = n_last; b_done = n_done;
        send_n(N, 1'b1);
        drain(1'b1);
        idle(2);
        chk("bp_outputs", n_out - b_out, N);
        chk("bp_last",    n_last - b_last, 1);
        chk("bp_done",    n_done - b_done, 1);

        // Flush after 7 outputs, then a full vector
        run_until_outputs(7);
        drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        tick(acc_g);
        idle(1);
        b_out = n_out; b_last = n_last; b_done = n_done;
        send_n(N, 1'b1);
        drain(1'b1);
        idle(2);
        chk("flush_outputs", n_out - b_out, N);
        chk("flush_last",    n_last - b_last, 1);
        chk("flush_done",    n_done - b_done, 1);

        // Same sequence with an asynchronous reset mid-vector
        run_until_outputs(7);
        repeat (2) begin
            @(posedge clk);
            #1;
            reset    = 1'b1;
            i_valid  = 1'b1;
            i_cstate = 8'($urandom);
        end
        b_out = n_out; b_last = n_last; b_done = n_done;
        send_n(N, 1'b1);
        drain(1'b1);
        idle(2);
        chk("reset_outputs", n_out - b_out, N);
        chk("reset_last",    n_last - b_last, 1);
        chk("reset_done",    n_done - b_done, 1);

        // Random soak with occasional flushes
        repeat (1500) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
            tick(acc_g);
        end
        drain(1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
